// File: rtl/xup_clk_pkg.sv
// Shared definitions for the clock divider controller: FSM encoding and
// the smallest divide ratio that yields a real half-period.
package xup_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/xup_div_counter.sv
// Half-period counter and clkout toggle flop. Holds the terminal value N and
// swaps in a pending N only on a toggle boundary so no half-period is cut short.
module xup_div_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] N_RST = '0
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             run,
  input  logic             n_wr,
  input  logic [WIDTH-1:0] n_wr_val,
  input  logic             pend_apply,
  input  logic [WIDTH-1:0] pend_val,
  output logic             wrap,
  output logic             clkout
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             clkout_q, clkout_d;

  // Compare with >= so a shrinking N can never leave count stranded above it.
  assign wrap   = run && (count_q >= n_q);
  assign clkout = clkout_q;

  always_comb begin
    count_d  = count_q;
    clkout_d = clkout_q;
    n_d      = n_q;
    if (!run) begin
      count_d  = '0;
      clkout_d = 1'b0;
    end else if (wrap) begin
      count_d  = '0;
      clkout_d = ~clkout_q;
    end else begin
      count_d  = count_q + WIDTH'(1);
    end
    if (n_wr)
      n_d = n_wr_val;
    else if (wrap && pend_apply)
      n_d = pend_val;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      count_q  <= '0;
      clkout_q <= 1'b0;
      n_q      <= N_RST;
    end else begin
      count_q  <= count_d;
      clkout_q <= clkout_d;
      n_q      <= n_d;
    end
  end

endmodule

// File: rtl/xup_clk_div_ctrl.sv
// Programmable glitch-free clock divider: run/stop FSM plus the divide-value
// load handshake; the counting itself lives in xup_div_counter.
module xup_clk_div_ctrl
  import xup_clk_pkg::*;
#(
  parameter int DEFAULT_DIV = 2,
  parameter int WIDTH       = 32
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic             clkout,
  output logic             tick,
  output logic             running
);

  localparam logic [WIDTH-1:0] N_RST = WIDTH'(DEFAULT_DIV / 2 - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_pend_q, n_pend_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             run;
  logic             accept;
  logic             direct;
  logic [WIDTH-1:0] n_new;

  assign run     = (state_q != ST_IDLE);
  assign running = run;
  assign busy    = busy_q;
  assign tick    = tick_q;
  assign div_ack = ack_q;
  assign div_err = err_q;
  assign n_new   = (div_value >> 1) - WIDTH'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      ST_STOP: begin
        if (enable)              state_d = ST_RUN;
        else if (wrap && clkout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loads are written straight into N whenever the divider is (or is about to be)
  // idle; otherwise they wait in n_pend for the next toggle boundary.
  always_comb begin
    accept   = div_load && !busy_q && (div_value >= WIDTH'(MIN_DIV));
    direct   = accept && (state_q == ST_IDLE || state_d == ST_IDLE);
    err_d    = div_load && !busy_q && (div_value < WIDTH'(MIN_DIV));
    ack_d    = accept;
    n_pend_d = n_pend_q;
    busy_d   = busy_q;
    if (busy_q) begin
      if (wrap) busy_d = 1'b0;
    end else if (accept && !direct) begin
      busy_d   = 1'b1;
      n_pend_d = n_new;
    end
    // The final fall into IDLE is not flagged so tick never shows up in IDLE.
    tick_d = wrap && (state_d != ST_IDLE);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      n_pend_q <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_pend_q <= n_pend_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  xup_div_counter #(
    .WIDTH (WIDTH),
    .N_RST (N_RST)
  ) u_cnt (
    .clkin      (clkin),
    .reset      (reset),
    .run        (run),
    .n_wr       (direct),
    .n_wr_val   (n_new),
    .pend_apply (busy_q),
    .pend_val   (n_pend_q),
    .wrap       (wrap),
    .clkout     (clkout)
  );

endmodule

// File: tb/tb_xup_clk_div_ctrl.sv
// Scoreboard bench for xup_clk_div_ctrl: a half-period reference model
// predicts every cycle's outputs; a monitor compares them on the falling edge.
module tb_xup_clk_div_ctrl;

  localparam int DEF_DIV = 2;
  localparam int W       = 32;

  logic         clkin = 1'b0;
  logic         reset;
  logic         enable;
  logic         div_load;
  logic [W-1:0] div_value;
  logic         div_ack, div_err, busy, clkout, tick, running;

  xup_clk_div_ctrl #(.DEFAULT_DIV(DEF_DIV), .WIDTH(W)) dut (
    .clkin     (clkin),
    .reset     (reset),
    .enable    (enable),
    .div_load  (div_load),
    .div_value (div_value),
    .div_ack   (div_ack),
    .div_err   (div_err),
    .busy      (busy),
    .clkout    (clkout),
    .tick      (tick),
    .running   (running)
  );

  always #5 clkin = ~clkin;

  // {clkout, tick, div_ack, div_err, busy, running}
  logic [5:0] exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  // Reference model state: half-period length in cycles, cycles elapsed in it.
  bit          m_active, m_prev_en, m_clk, m_pending;
  int unsigned m_elapsed, m_half, m_pend_half;

  task automatic step(input bit r, input bit e, input bit l, input int unsigned d);
    logic [5:0] x;
    bit bnd, go_idle, acc, bad, t;
    reset = r; enable = e; div_load = l; div_value = d;
    t = 0; acc = 0; bad = 0;
    if (r) begin
      m_active = 0; m_prev_en = 0; m_clk = 0; m_pending = 0;
      m_elapsed = 0; m_half = DEF_DIV / 2; m_pend_half = 0;
    end else begin
      bnd     = m_active && (m_elapsed + 1 >= m_half);
      go_idle = m_active && !m_prev_en && !e && bnd && m_clk;
      bad     = l && !m_pending && d < 2;
      acc     = l && !m_pending && d >= 2;
      t       = bnd && !go_idle;
      if (bnd && m_pending) begin m_half = m_pend_half; m_pending = 0; end
      if (acc) begin
        if (!m_active || go_idle) m_half = d / 2;
        else begin m_pend_half = d / 2; m_pending = 1; end
      end
      if (!m_active) begin
        m_active = e; m_elapsed = 0;
      end else if (bnd) begin
        m_elapsed = 0; m_clk = !m_clk;
        if (go_idle) m_active = 0;
      end else begin
        m_elapsed++;
      end
      m_prev_en = e;
    end
    x = {m_clk, t, acc, bad, m_pending, m_active};
    @(posedge clkin);
    exp_q.push_back(x);
    #1;
  endtask

  task automatic run_n(input int n, input bit e);
    for (int i = 0; i < n; i++) step(0, e, 0, 0);
  endtask

  // Monitor: one scoreboard entry becomes due per clock edge.
  initial begin
    logic [5:0] want, got;
    forever begin
      @(negedge clkin);
      cyc++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {clkout, tick, div_ack, div_err, busy, running};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          if (n_bad <= 30)
            $display("FAIL outputs cyc=%0d got clk/tick/ack/err/busy/run=%b want=%b",
                     cyc, got, want);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit en;
    reset = 1; enable = 0; div_load = 0; div_value = '0;
    #1;
    // reset state, with inputs that must be ignored during reset
    step(1, 0, 0, 0);
    step(1, 1, 1, 10);
    step(1, 0, 0, 0);
    // default divide: toggle every cycle
    run_n(12, 1);
    run_n(6, 0);
    // idle load D=10 then 5 high / 5 low
    step(0, 0, 1, 10);
    run_n(2, 0);
    run_n(30, 1);
    // mid-half-period reload to D=4
    run_n(2, 1);
    step(0, 1, 1, 4);
    run_n(20, 1);
    // rejected ratios, then odd D=7
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    run_n(3, 1);
    step(0, 1, 1, 7);
    run_n(20, 1);
    // D=8: drop enable in each clkout phase
    step(0, 1, 1, 8);
    run_n(20, 1);
    while (!m_clk) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    run_n(14, 0);
    run_n(9, 1);
    while (m_clk) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    run_n(20, 0);
    // load while busy is ignored; reset with a pending load
    run_n(3, 1);
    step(0, 1, 1, 12);
    step(0, 1, 1, 6);
    step(0, 1, 1, 1);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    // load and enable rising together from IDLE
    step(0, 1, 1, 6);
    run_n(15, 1);
    // randomized traffic
    en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) en = !en;
      step($urandom_range(0, 299) == 0, en, $urandom_range(0, 5) == 0,
           $urandom_range(0, 11));
    end
    run_n(30, 0);
    @(negedge clkin);
    @(negedge clkin);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain queue left=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
